// File: rtl/dual_input_debouncer.sv
// Two independent raw-input debouncers (2-flop sync + stability FSM); out follows raw after DEBOUNCE_CYCLES+2 edges, no backpressure.
// Optional DEBOUNCE_LOCKOUT_EN: after each out change the channel ignores its input for DEBOUNCE_CYCLES cycles (HOLD).

module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic out,
  output logic chg,
  output logic idle
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef DEBOUNCE_LOCKOUT_EN
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, HOLD = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, CHECK = 1'b1} state_t;
`endif

  logic             s1, s2;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             out_nxt, chg_nxt;

  // raw is asynchronous; only s2 is ever looked at by the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      out   <= 1'b0;
      chg   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      out   <= out_nxt;
      chg   <= chg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = out;
    chg_nxt   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (s2 != out) begin
          if (DEBOUNCE_CYCLES == 1) begin
            out_nxt = s2;
            chg_nxt = 1'b1;
`ifdef DEBOUNCE_LOCKOUT_EN
            state_nxt = HOLD;
            cnt_nxt   = CNT_ONE;
`endif
          end else begin
            state_nxt = CHECK;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      CHECK: begin
        if (s2 == out) begin
          // bounce back: qualification restarts from zero
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          out_nxt = s2;
          chg_nxt = 1'b1;
`ifdef DEBOUNCE_LOCKOUT_EN
          state_nxt = HOLD;
          cnt_nxt   = CNT_ONE;
`else
          state_nxt = IDLE;
          cnt_nxt   = '0;
`endif
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
`ifdef DEBOUNCE_LOCKOUT_EN
      HOLD: begin
        if (cnt == CNT_MAX) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign idle = (state == IDLE);

endmodule

module dual_input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_chg,
  output logic b_chg,
  output logic stable
);
  logic a_idle, b_idle;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_a (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (a_raw),
    .out  (a),
    .chg  (a_chg),
    .idle (a_idle)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan_b (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (b_raw),
    .out  (b),
    .chg  (b_chg),
    .idle (b_idle)
  );

  assign stable = a_idle && b_idle;

endmodule
